// File: rtl/sdcard_err_pkg.sv
// Shared types for the SD card error manager: FSM states, history entry layout
// and the entry-width helper used by the top, the interface and the FIFO.
package sdcard_err_pkg;

  typedef enum logic [1:0] {IDLE, CAPTURE, RETRY, REPORT} err_mgr_state_t;

  localparam int RC_W = 3;

  function automatic int entry_w(int num_src, int ts_w);
    return $clog2(num_src) + ts_w + RC_W + 1;
  endfunction

  localparam int ENTRY_W = entry_w(8, 16);

  typedef struct packed {
    logic [2:0]      src;
    logic [15:0]     ts;
    logic [RC_W-1:0] retries;
    logic            fatal;
  } err_hist_entry_t;

endpackage

// File: rtl/sdcard_error_manager_if.sv
// Bus between the error manager and its host: error inputs, retry handshake,
// status/irq outputs and the history read port.
interface sdcard_error_manager_if import sdcard_err_pkg::*; #(
  parameter int NUM_SRC = 8,
  parameter int CNT_W   = 16,
  parameter int TS_W    = 16
);
  localparam int SRC_W = $clog2(NUM_SRC);
  localparam int EW    = entry_w(NUM_SRC, TS_W);

  logic [NUM_SRC-1:0] err_src_i, irq_en_i, status_clr_i, status_o;
  logic [CNT_W-1:0]   threshold_i, err_count_o;
  logic               retry_req_o, retry_ack_i, retry_ok_i;
  logic [SRC_W-1:0]   retry_src_o;
  logic               irq_o, fatal_o, thresh_o;
  logic               hist_valid_o, hist_rd_i, hist_ovf_o, hist_ovf_clr_i;
  logic [EW-1:0]      hist_data_o;

  modport master (
    output err_src_i, irq_en_i, status_clr_i, threshold_i, retry_ack_i, retry_ok_i,
           hist_rd_i, hist_ovf_clr_i,
    input  retry_req_o, retry_src_o, status_o, irq_o, fatal_o, thresh_o, err_count_o,
           hist_valid_o, hist_data_o, hist_ovf_o
  );

  modport slave (
    input  err_src_i, irq_en_i, status_clr_i, threshold_i, retry_ack_i, retry_ok_i,
           hist_rd_i, hist_ovf_clr_i,
    output retry_req_o, retry_src_o, status_o, irq_o, fatal_o, thresh_o, err_count_o,
           hist_valid_o, hist_data_o, hist_ovf_o
  );
endinterface

// File: rtl/sdcard_err_hist_fifo.sv
// Show-ahead history FIFO; a push that finds it full (without a same-cycle pop)
// is dropped and latches the overflow flag.
module sdcard_err_hist_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 23
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  input  logic         ovf_clr,
  output logic [W-1:0] dout,
  output logic         valid,
  output logic         ovf
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   cnt;
  logic          do_push, do_pop;

  assign valid   = cnt != '0;
  assign do_pop  = pop & valid;
  assign do_push = push & ((cnt != (AW+1)'(DEPTH)) | do_pop);
  assign dout    = valid ? mem[rptr] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
      ovf  <= 1'b0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
      // a drop in the same cycle as a clear keeps the flag set
      ovf <= (ovf & ~ovf_clr) | (push & ~do_push);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end
endmodule

// File: rtl/sdcard_error_manager.sv
// Multi-source error manager: edge detect, fixed-priority arbitration, bounded
// retry handshake, sticky status/fatal/threshold and history logging.
module sdcard_error_manager import sdcard_err_pkg::*; #(
  parameter int                 NUM_SRC    = 8,
  parameter int                 HIST_DEPTH = 8,
  parameter int                 TS_W       = 16,
  parameter int                 CNT_W      = 16,
  parameter int                 MAX_RETRY  = 3,
  parameter int                 RETRY_TO   = 255,
  parameter logic [NUM_SRC-1:0] RECOV_MASK = 8'h8F,
  parameter logic [NUM_SRC-1:0] FATAL_MASK = 8'h30
) (
  input logic                  PCLK_i,
  input logic                  PRESETn_i,
  sdcard_error_manager_if.slave bus
);
  localparam int SRC_W = $clog2(NUM_SRC);
  localparam int EW    = entry_w(NUM_SRC, TS_W);
  localparam int TMR_W = (RETRY_TO < 2) ? 1 : $clog2(RETRY_TO + 1);

  err_mgr_state_t                 state, state_nxt;
  logic [NUM_SRC-1:0]             err_q, rise, pend, status, rep_vec;
  logic [NUM_SRC-1:0][RC_W-1:0]   retries;
  logic [SRC_W-1:0]               cur_src, pick;
  logic [TS_W-1:0]                ts, cur_ts;
  logic [TMR_W-1:0]               timer;
  logic [CNT_W-1:0]               err_count;
  logic                           fatal, thresh, irq;
  logic                           in_capture, in_retry, in_report, ack_ok, retry_fail;

  assign rise       = bus.err_src_i & ~err_q;
  assign in_capture = state == CAPTURE;
  assign in_retry   = state == RETRY;
  assign in_report  = state == REPORT;
  assign ack_ok     = in_retry & bus.retry_ack_i & bus.retry_ok_i;
  assign retry_fail = in_retry & ~ack_ok & (bus.retry_ack_i | (timer == TMR_W'(RETRY_TO)));
  assign rep_vec    = in_report ? (NUM_SRC'(1) << cur_src) : '0;

  // lowest pending index wins
  always_comb begin
    pick = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--)
      if (pend[i]) pick = SRC_W'(i);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|pend) state_nxt = CAPTURE;
      CAPTURE: state_nxt = (RECOV_MASK[cur_src] && retries[cur_src] < RC_W'(MAX_RETRY))
                           ? RETRY : REPORT;
      RETRY:   if (ack_ok || retry_fail) state_nxt = IDLE;
      REPORT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge PCLK_i or negedge PRESETn_i) begin
    if (!PRESETn_i) begin
      state     <= IDLE;
      err_q     <= '0;
      cur_src   <= '0;
      cur_ts    <= '0;
      ts        <= '0;
      timer     <= '0;
      err_count <= '0;
      status    <= '0;
      fatal     <= 1'b0;
      thresh    <= 1'b0;
      irq       <= 1'b0;
    end else begin
      state <= state_nxt;
      err_q <= bus.err_src_i;
      ts    <= ts + 1'b1;
      timer <= in_retry ? timer + 1'b1 : '0;
      if (state == IDLE && |pend) begin
        cur_src <= pick;
        cur_ts  <= ts;
      end
      // only the first capture of an event counts; re-arbitrated retries do not
      if (in_capture && retries[cur_src] == '0 && !(&err_count))
        err_count <= err_count + 1'b1;
      status <= (status & ~bus.status_clr_i) | rep_vec;
      if (in_report && FATAL_MASK[cur_src]) fatal <= 1'b1;
      if (bus.threshold_i != '0 && err_count >= bus.threshold_i) thresh <= 1'b1;
      irq <= (|(status & bus.irq_en_i)) | thresh;
    end
  end

  // per-source pending flag and retry counter; a fresh edge beats a same-cycle clear
  always_ff @(posedge PCLK_i or negedge PRESETn_i) begin
    if (!PRESETn_i) begin
      pend    <= '0;
      retries <= '0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (cur_src == SRC_W'(i) && (ack_ok || in_report)) begin
          pend[i]    <= rise[i];
          retries[i] <= '0;
        end else begin
          pend[i] <= pend[i] | rise[i];
          if (cur_src == SRC_W'(i) && retry_fail) retries[i] <= retries[i] + 1'b1;
        end
      end
    end
  end

  sdcard_err_hist_fifo #(.DEPTH(HIST_DEPTH), .W(EW)) u_hist (
    .clk     (PCLK_i),
    .rst_n   (PRESETn_i),
    .push    (in_report),
    .din     ({cur_src, cur_ts, retries[cur_src], FATAL_MASK[cur_src]}),
    .pop     (bus.hist_rd_i),
    .ovf_clr (bus.hist_ovf_clr_i),
    .dout    (bus.hist_data_o),
    .valid   (bus.hist_valid_o),
    .ovf     (bus.hist_ovf_o)
  );

  assign bus.retry_req_o = in_retry;
  assign bus.retry_src_o = cur_src;
  assign bus.status_o    = status;
  assign bus.irq_o       = irq;
  assign bus.fatal_o     = fatal;
  assign bus.thresh_o    = thresh;
  assign bus.err_count_o = err_count;
endmodule

// File: tb/tb_sdcard_error_manager.sv
// Directed bench for sdcard_error_manager; inputs change and outputs are
// sampled on the falling clock edge.
module tb_sdcard_error_manager;
  import sdcard_err_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sdcard_error_manager_if bus ();

  sdcard_error_manager dut (
    .PCLK_i    (clk),
    .PRESETn_i (rst_n),
    .bus       (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  err_hist_entry_t e;

  task automatic drive_idle;
    bus.err_src_i      = '0;
    bus.irq_en_i       = '0;
    bus.status_clr_i   = '0;
    bus.threshold_i    = '0;
    bus.retry_ack_i    = 1'b0;
    bus.retry_ok_i     = 1'b0;
    bus.hist_rd_i      = 1'b0;
    bus.hist_ovf_clr_i = 1'b0;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    drive_idle();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    drive_idle();
    @(negedge clk);
    n_cmp++; if (bus.status_o !== 8'h00) begin n_bad++; $display("FAIL rst_status got=%h exp=00", bus.status_o); end
    n_cmp++; if (bus.err_count_o !== 16'd0) begin n_bad++; $display("FAIL rst_count got=%0d exp=0", bus.err_count_o); end
    n_cmp++; if ({bus.irq_o, bus.fatal_o, bus.thresh_o, bus.retry_req_o} !== 4'b0000) begin n_bad++; $display("FAIL rst_flags got=%b exp=0000", {bus.irq_o, bus.fatal_o, bus.thresh_o, bus.retry_req_o}); end
    n_cmp++; if ({bus.hist_valid_o, bus.hist_ovf_o} !== 2'b00 || bus.hist_data_o !== '0) begin n_bad++; $display("FAIL rst_hist got=%b/%h exp=00/0", {bus.hist_valid_o, bus.hist_ovf_o}, bus.hist_data_o); end
  endtask

  // held level on a fatal, non-recoverable source reports exactly once
  task automatic test_single_fatal;
    do_reset();
    bus.irq_en_i  = '1;
    bus.err_src_i = 8'h10;
    repeat (3) @(negedge clk);
    n_cmp++; if (bus.status_o !== 8'h00) begin n_bad++; $display("FAIL t1_status_early got=%h exp=00", bus.status_o); end
    @(negedge clk);
    n_cmp++; if (bus.status_o !== 8'h10) begin n_bad++; $display("FAIL t1_status got=%h exp=10", bus.status_o); end
    n_cmp++; if (bus.fatal_o !== 1'b1) begin n_bad++; $display("FAIL t1_fatal got=%b exp=1", bus.fatal_o); end
    @(negedge clk);
    n_cmp++; if (bus.irq_o !== 1'b1) begin n_bad++; $display("FAIL t1_irq got=%b exp=1", bus.irq_o); end
    repeat (15) @(negedge clk);
    n_cmp++; if (bus.err_count_o !== 16'd1) begin n_bad++; $display("FAIL t1_count got=%0d exp=1", bus.err_count_o); end
    e = bus.hist_data_o;
    n_cmp++; if (bus.hist_valid_o !== 1'b1 || e.src !== 3'd4 || e.ts !== 16'd1 || e.retries !== 3'd0 || e.fatal !== 1'b1)
      begin n_bad++; $display("FAIL t1_hist got=v%b src%0d ts%0d r%0d f%b exp=v1 src4 ts1 r0 f1", bus.hist_valid_o, e.src, e.ts, e.retries, e.fatal); end
    bus.hist_rd_i = 1'b1;
    @(negedge clk);
    bus.hist_rd_i = 1'b0;
    n_cmp++; if (bus.hist_valid_o !== 1'b0) begin n_bad++; $display("FAIL t1_hist_empty got=%b exp=0", bus.hist_valid_o); end
  endtask

  task automatic test_retry_fail;
    int  pulses = 0;
    bit  seen, extra;
    do_reset();
    bus.irq_en_i  = '1;
    bus.err_src_i = 8'h01;
    for (int k = 0; k < 3; k++) begin
      seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin @(negedge clk); seen = bus.retry_req_o; end
      if (seen) begin
        pulses++;
        n_cmp++; if (bus.retry_src_o !== 3'd0) begin n_bad++; $display("FAIL t2_src got=%0d exp=0", bus.retry_src_o); end
        bus.retry_ack_i = 1'b1;
        bus.retry_ok_i  = 1'b0;
        @(negedge clk);
        bus.retry_ack_i = 1'b0;
        n_cmp++; if (bus.retry_req_o !== 1'b0) begin n_bad++; $display("FAIL t2_req_drop got=%b exp=0", bus.retry_req_o); end
      end
    end
    n_cmp++; if (pulses !== 3) begin n_bad++; $display("FAIL t2_pulses got=%0d exp=3", pulses); end
    extra = 1'b0;
    for (int c = 0; c < 3; c++) begin @(negedge clk); extra |= bus.retry_req_o; end
    n_cmp++; if (extra !== 1'b0) begin n_bad++; $display("FAIL t2_no_4th_retry got=%b exp=0", extra); end
    n_cmp++; if (bus.status_o !== 8'h01) begin n_bad++; $display("FAIL t2_status got=%h exp=01", bus.status_o); end
    @(negedge clk);
    n_cmp++; if (bus.irq_o !== 1'b1) begin n_bad++; $display("FAIL t2_irq got=%b exp=1", bus.irq_o); end
    n_cmp++; if (bus.err_count_o !== 16'd1) begin n_bad++; $display("FAIL t2_count got=%0d exp=1", bus.err_count_o); end
    e = bus.hist_data_o;
    n_cmp++; if (e.src !== 3'd0 || e.retries !== 3'd3 || e.fatal !== 1'b0 || bus.fatal_o !== 1'b0)
      begin n_bad++; $display("FAIL t2_hist got=src%0d r%0d f%b fatal%b exp=src0 r3 f0 fatal0", e.src, e.retries, e.fatal, bus.fatal_o); end
  endtask

  task automatic test_retry_timeout;
    int len;
    bit seen;
    do_reset();
    bus.err_src_i = 8'h02;
    for (int k = 0; k < 3; k++) begin
      seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin @(negedge clk); seen = bus.retry_req_o; end
      len = 0;
      while (bus.retry_req_o && len < 400) begin len++; @(negedge clk); end
      n_cmp++; if (len !== 256) begin n_bad++; $display("FAIL t3_req_len%0d got=%0d exp=256", k, len); end
    end
    repeat (3) @(negedge clk);
    n_cmp++; if (bus.status_o !== 8'h02) begin n_bad++; $display("FAIL t3_status got=%h exp=02", bus.status_o); end
    n_cmp++; if (bus.err_count_o !== 16'd1) begin n_bad++; $display("FAIL t3_count got=%0d exp=1", bus.err_count_o); end
  endtask

  task automatic test_priority;
    bit seen = 1'b0;
    do_reset();
    bus.err_src_i = 8'h44;
    for (int c = 0; c < 20 && !seen; c++) begin @(negedge clk); seen = bus.retry_req_o; end
    n_cmp++; if (!seen || bus.retry_src_o !== 3'd2) begin n_bad++; $display("FAIL t4_first got=req%b src%0d exp=req1 src2", seen, bus.retry_src_o); end
    bus.retry_ack_i = 1'b1;
    bus.retry_ok_i  = 1'b1;
    @(negedge clk);
    bus.retry_ack_i = 1'b0;
    bus.retry_ok_i  = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (bus.status_o !== 8'h40) begin n_bad++; $display("FAIL t4_status got=%h exp=40", bus.status_o); end
    n_cmp++; if (bus.err_count_o !== 16'd2) begin n_bad++; $display("FAIL t4_count got=%0d exp=2", bus.err_count_o); end
    e = bus.hist_data_o;
    n_cmp++; if (bus.hist_valid_o !== 1'b1 || e.src !== 3'd6) begin n_bad++; $display("FAIL t4_hist got=v%b src%0d exp=v1 src6", bus.hist_valid_o, e.src); end
    bus.hist_rd_i = 1'b1;
    @(negedge clk);
    bus.hist_rd_i = 1'b0;
    n_cmp++; if (bus.hist_valid_o !== 1'b0) begin n_bad++; $display("FAIL t4_single_entry got=%b exp=0", bus.hist_valid_o); end
  endtask

  task automatic test_fifo_overflow;
    logic [15:0] prev_ts = '0;
    do_reset();
    for (int k = 0; k < 9; k++) begin
      bus.err_src_i = 8'(1 << (4 + k % 3));
      @(negedge clk);
      bus.err_src_i = '0;
      repeat (4) @(negedge clk);
    end
    n_cmp++; if (bus.err_count_o !== 16'd9) begin n_bad++; $display("FAIL t5_count got=%0d exp=9", bus.err_count_o); end
    n_cmp++; if (bus.hist_ovf_o !== 1'b1) begin n_bad++; $display("FAIL t5_ovf got=%b exp=1", bus.hist_ovf_o); end
    for (int j = 0; j < 8; j++) begin
      e = bus.hist_data_o;
      n_cmp++; if (bus.hist_valid_o !== 1'b1 || e.src !== 3'(4 + j % 3)) begin n_bad++; $display("FAIL t5_pop%0d got=v%b src%0d exp=v1 src%0d", j, bus.hist_valid_o, e.src, 4 + j % 3); end
      if (j > 0) begin
        n_cmp++; if (e.ts - prev_ts !== 16'd5) begin n_bad++; $display("FAIL t5_ts_gap%0d got=%0d exp=5", j, e.ts - prev_ts); end
      end
      prev_ts = e.ts;
      bus.hist_rd_i = 1'b1;
      @(negedge clk);
      bus.hist_rd_i = 1'b0;
    end
    n_cmp++; if (bus.hist_valid_o !== 1'b0) begin n_bad++; $display("FAIL t5_drained got=%b exp=0", bus.hist_valid_o); end
    bus.hist_ovf_clr_i = 1'b1;
    @(negedge clk);
    bus.hist_ovf_clr_i = 1'b0;
    n_cmp++; if (bus.hist_ovf_o !== 1'b0) begin n_bad++; $display("FAIL t5_ovf_clr got=%b exp=0", bus.hist_ovf_o); end
  endtask

  task automatic test_threshold;
    do_reset();
    bus.threshold_i = 16'd2;
    for (int k = 0; k < 2; k++) begin
      bus.err_src_i = 8'h40;
      @(negedge clk);
      bus.err_src_i = '0;
      repeat (4) @(negedge clk);
      n_cmp++; if (bus.thresh_o !== (k == 1)) begin n_bad++; $display("FAIL t6_thresh_ev%0d got=%b exp=%b", k, bus.thresh_o, k == 1); end
    end
    n_cmp++; if (bus.irq_o !== 1'b1) begin n_bad++; $display("FAIL t6_irq got=%b exp=1", bus.irq_o); end
    // third event: a W1C landing on the REPORT edge must not win
    bus.err_src_i = 8'h40;
    @(negedge clk);
    bus.err_src_i = '0;
    repeat (2) @(negedge clk);
    bus.status_clr_i = '1;
    @(negedge clk);
    bus.status_clr_i = '0;
    n_cmp++; if (bus.status_o !== 8'h40) begin n_bad++; $display("FAIL t6_set_wins got=%h exp=40", bus.status_o); end
    n_cmp++; if (bus.err_count_o !== 16'd3) begin n_bad++; $display("FAIL t6_count got=%0d exp=3", bus.err_count_o); end
    @(negedge clk);
    bus.status_clr_i = '1;
    @(negedge clk);
    bus.status_clr_i = '0;
    n_cmp++; if (bus.status_o !== 8'h00) begin n_bad++; $display("FAIL t6_clr got=%h exp=00", bus.status_o); end
    n_cmp++; if (bus.thresh_o !== 1'b1) begin n_bad++; $display("FAIL t6_thresh_sticky got=%b exp=1", bus.thresh_o); end
  endtask

  task automatic test_reset_abort;
    bit seen = 1'b0;
    do_reset();
    bus.err_src_i = 8'h01;
    for (int c = 0; c < 20 && !seen; c++) begin @(negedge clk); seen = bus.retry_req_o; end
    n_cmp++; if (!seen) begin n_bad++; $display("FAIL t7_req got=0 exp=1"); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.retry_req_o !== 1'b0) begin n_bad++; $display("FAIL t7_abort got=%b exp=0", bus.retry_req_o); end
    bus.err_src_i = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single_fatal();
    test_retry_fail();
    test_retry_timeout();
    test_priority();
    test_fifo_overflow();
    test_threshold();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
